// File: rtl/commit_flush_sequencer_pkg.sv
// Shared types for the commit flush sequencer: FSM states, flush plan and
// the ordering helper that picks the next planned flush step.
package commit_flush_sequencer_pkg;

  // Minimal core-configuration record; only XLEN is sanity-checked here.
  typedef struct packed {
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t CfgEmpty = '{XLEN: 64};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_DCACHE = 3'd2,
    ST_ICACHE = 3'd3,
    ST_TLB    = 3'd4,
    ST_PIPE   = 3'd5
  } flush_seq_state_e;

  typedef struct packed {
    logic dc;
    logic ic;
    logic tlb;
  } flush_plan_t;

  // Fixed order DRAIN -> DCACHE -> ICACHE -> TLB -> PIPE, skipping unplanned steps.
  function automatic flush_seq_state_e next_planned(flush_seq_state_e from,
                                                    flush_plan_t      plan);
    flush_seq_state_e nxt;
    nxt = ST_PIPE;
    if (from == ST_DRAIN && plan.dc) begin
      nxt = ST_DCACHE;
    end else if ((from == ST_DRAIN || from == ST_DCACHE) && plan.ic) begin
      nxt = ST_ICACHE;
    end else if ((from == ST_DRAIN || from == ST_DCACHE || from == ST_ICACHE) && plan.tlb) begin
      nxt = ST_TLB;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/commit_flush_sequencer_flush_watchdog.sv
// Cycle counter for the flush watchdog; expired_o is a decode of the count
// reaching Cycles-1. Used by commit_flush_sequencer under COMMIT_FLUSH_WDOG_EN.
module flush_watchdog #(
  parameter int unsigned Cycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(Cycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/commit_flush_sequencer.sv
// Orders FENCE / FENCE.I / SFENCE.VMA flush work: store drain, D$, I$, TLB,
// then one pipeline flush. Optional watchdog: define COMMIT_FLUSH_WDOG_EN.
module commit_flush_sequencer
  import commit_flush_sequencer_pkg::*;
#(
  parameter cfg_t        CVA6Cfg    = CfgEmpty,
  parameter int unsigned WdogCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fence_req_i,
  input  logic fence_i_req_i,
  input  logic sfence_vma_req_i,
  output logic ready_o,
  input  logic no_st_pending_i,
  output logic dcache_flush_o,
  input  logic dcache_flush_ack_i,
  output logic icache_flush_o,
  output logic tlb_flush_o,
  output logic flush_pipe_o,
  output logic done_o,
  output logic err_timeout_o
);

  if (WdogCycles < 2 || CVA6Cfg.XLEN == 0) begin : g_bad_cfg
    $error("commit_flush_sequencer: WdogCycles must be >= 2 and XLEN non-zero");
  end

  flush_seq_state_e state_q, state_d;
  flush_plan_t      plan_q, plan_d;
  logic             dc_q, ic_q, tlb_q, pipe_q;
  logic             wd_active;
  logic             timeout;

  assign wd_active = (state_q == ST_DRAIN) || (state_q == ST_DCACHE);

`ifdef COMMIT_FLUSH_WDOG_EN
  logic wd_expired;

  flush_watchdog #(
    .Cycles(WdogCycles)
  ) u_flush_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (wd_active),
    .clr_i    (!wd_active),
    .expired_o(wd_expired)
  );

  assign timeout       = wd_active && wd_expired;
  assign err_timeout_o = timeout;
`else
  assign timeout       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    plan_d  = plan_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fence_req_i || fence_i_req_i || sfence_vma_req_i) begin
          plan_d.dc  = fence_req_i || fence_i_req_i;
          plan_d.ic  = fence_i_req_i;
          plan_d.tlb = sfence_vma_req_i;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (timeout) begin
          state_d = ST_PIPE;
        end else if (no_st_pending_i) begin
          state_d = next_planned(ST_DRAIN, plan_q);
        end
      end
      ST_DCACHE: begin
        if (timeout) begin
          state_d = ST_PIPE;
        end else if (dcache_flush_ack_i) begin
          state_d = next_planned(ST_DCACHE, plan_q);
        end
      end
      ST_ICACHE: state_d = next_planned(ST_ICACHE, plan_q);
      ST_TLB:    state_d = ST_PIPE;
      ST_PIPE: begin
        state_d = ST_IDLE;
        plan_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        plan_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      plan_q  <= '0;
      dc_q    <= 1'b0;
      ic_q    <= 1'b0;
      tlb_q   <= 1'b0;
      pipe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plan_q  <= plan_d;
      dc_q    <= (state_d == ST_DCACHE);
      ic_q    <= (state_d == ST_ICACHE);
      tlb_q   <= (state_d == ST_TLB);
      pipe_q  <= (state_d == ST_PIPE);
    end
  end

  assign ready_o        = (state_q == ST_IDLE);
  assign dcache_flush_o = dc_q;
  assign icache_flush_o = ic_q;
  assign tlb_flush_o    = tlb_q;
  assign flush_pipe_o   = pipe_q;
  assign done_o         = pipe_q;

endmodule

// File: tb/tb_commit_flush_sequencer.sv
// Directed bench for commit_flush_sequencer; the watchdog case follows
// COMMIT_FLUSH_WDOG_EN. Observed vector: {ready,dc,ic,tlb,pipe,done,err}.
module tb_commit_flush_sequencer;

`ifdef COMMIT_FLUSH_WDOG_EN
  localparam int unsigned WDOG = 16;
`else
  localparam int unsigned WDOG = 1024;
`endif

  logic clk = 1'b0;
  logic rst, fence, fence_i, sfence, no_st, ack;
  logic ready, dc, ic, tlb, pipe, done, err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  commit_flush_sequencer #(
    .WdogCycles(WDOG)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .fence_req_i       (fence),
    .fence_i_req_i     (fence_i),
    .sfence_vma_req_i  (sfence),
    .ready_o           (ready),
    .no_st_pending_i   (no_st),
    .dcache_flush_o    (dc),
    .dcache_flush_ack_i(ack),
    .icache_flush_o    (ic),
    .tlb_flush_o       (tlb),
    .flush_pipe_o      (pipe),
    .done_o            (done),
    .err_timeout_o     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  function automatic logic [31:0] obs();
    return {25'd0, ready, dc, ic, tlb, pipe, done, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] V_IDLE = 32'b1000000;
  localparam logic [31:0] V_BUSY = 32'b0000000;
  localparam logic [31:0] V_DC   = 32'b0100000;
  localparam logic [31:0] V_IC   = 32'b0010000;
  localparam logic [31:0] V_TLB  = 32'b0001000;
  localparam logic [31:0] V_PIPE = 32'b0000110;
  localparam logic [31:0] V_TOUT = 32'b0100001;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] e;
    int unsigned ndone;
    rst = 1'b1; fence = 1'b0; fence_i = 1'b0; sfence = 1'b0; no_st = 1'b1; ack = 1'b0;
    tick(); tick();
    check_eq("reset", obs(), V_IDLE);
    rst = 1'b0;
    tick();
    check_eq("idle", obs(), V_IDLE);

    // SFENCE.VMA, store buffer empty
    sfence = 1'b1; tick(); sfence = 1'b0;
    check_eq("sf_c1", obs(), V_BUSY); tick();
    check_eq("sf_c2", obs(), V_TLB);  tick();
    check_eq("sf_c3", obs(), V_PIPE); tick();
    check_eq("sf_c4", obs(), V_IDLE); tick();

    // FENCE.I with stalled drain (cycles 1-5) and ack 3 cycles into DCACHE
    fence_i = 1'b1; no_st = 1'b0; tick(); fence_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      no_st = (c >= 6);
      ack   = (c == 9);
      if (c <= 6) e = V_BUSY;
      else if (c <= 9) e = V_DC;
      else if (c == 10) e = V_IC;
      else if (c == 11) e = V_PIPE;
      else e = V_IDLE;
      check_eq($sformatf("fi_c%0d", c), obs(), e);
      tick();
    end
    ack = 1'b0; no_st = 1'b1;

    // FENCE + SFENCE.VMA together: one sequence, DCACHE then TLB
    fence = 1'b1; sfence = 1'b1; tick(); fence = 1'b0; sfence = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      ack = (c == 3);
      case (c)
        1:       e = V_BUSY;
        2, 3:    e = V_DC;
        4:       e = V_TLB;
        5:       e = V_PIPE;
        default: e = V_IDLE;
      endcase
      check_eq($sformatf("fs_c%0d", c), obs(), e);
      if (done) ndone++;
      tick();
    end
    ack = 1'b0;
    check_eq("fs_done_count", ndone, 32'd1);

    // Stray ack in IDLE, then requests while busy
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("stray_ack", obs(), V_IDLE);
    sfence = 1'b1; tick(); sfence = 1'b0;
    no_st = 1'b0; fence_i = 1'b1;
    check_eq("busy_c1", obs(), V_BUSY); tick();
    no_st = 1'b1;
    check_eq("busy_c2", obs(), V_BUSY); tick();
    fence_i = 1'b0;
    check_eq("busy_c3", obs(), V_TLB);  tick();
    check_eq("busy_c4", obs(), V_PIPE); tick();
    check_eq("busy_c5", obs(), V_IDLE); tick();

    // Reset in the middle of DCACHE
    fence = 1'b1; tick(); fence = 1'b0;
    tick();
    check_eq("rst_pre", obs(), V_DC);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_mid", obs(), V_IDLE);
    ack = 1'b1; tick(); ack = 1'b0;
    check_eq("rst_after1", obs(), V_IDLE); tick();
    check_eq("rst_after2", obs(), V_IDLE); tick();

    // FENCE with no ack: watchdog abort if enabled, otherwise indefinite wait
    fence = 1'b1; tick(); fence = 1'b0;
`ifdef COMMIT_FLUSH_WDOG_EN
    for (int c = 1; c <= 18; c++) begin
      if (c == 1) e = V_BUSY;
      else if (c <= 15) e = V_DC;
      else if (c == 16) e = V_TOUT;
      else if (c == 17) e = V_PIPE;
      else e = V_IDLE;
      check_eq($sformatf("wd_c%0d", c), obs(), e);
      tick();
    end
`else
    for (int c = 1; c <= 42; c++) begin
      ack = (c == 40);
      if (c == 1) e = V_BUSY;
      else if (c <= 40) e = V_DC;
      else if (c == 41) e = V_PIPE;
      else e = V_IDLE;
      if (c == 1 || c == 2 || c >= 16) check_eq($sformatf("wait_c%0d", c), obs(), e);
      tick();
    end
    ack = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
